// File: rtl/sprite_rom_arbiter_if.sv
// Sprite ROM arbiter bus.
// Groups the requester-side handshake and the ROM-side port.
//   req, req_lock, req_addr : requester read request, burst hold, packed addresses
//   grant                   : one-hot (or zero) grant, combinational
//   rom_addr, rom_rden      : registered ROM address / read enable
//   rom_q                   : ROM read data
//   rdata, rdata_valid      : registered shared read data and one-hot owner tag
// slave  = arbiter view, master = environment (requesters + ROM) view.
interface sprite_rom_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int AW    = 12,
  parameter int DW    = 12
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    req_lock;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ-1:0]    grant;
  logic [AW-1:0]       rom_addr;
  logic                rom_rden;
  logic [DW-1:0]       rom_q;
  logic [DW-1:0]       rdata;
  logic [N_REQ-1:0]    rdata_valid;

  modport slave (
    input  req, req_lock, req_addr, rom_q,
    output grant, rom_addr, rom_rden, rdata, rdata_valid
  );

  modport master (
    output req, req_lock, req_addr, rom_q,
    input  grant, rom_addr, rom_rden, rdata, rdata_valid
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: round-robin arbitration of N_REQ requesters
// (0 player, 1 invader, 2 bullet, 3 shield) onto one sprite ROM, with
// optional locked bursts of up to MAX_BURST grants, a registered issue
// stage, an RD_LAT-deep owner tag pipeline and a per-frame conflict counter.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   frame_start   : single-cycle pulse at line 0 / pixel 0
//   bus (slave)   : requester and ROM signals, see sprite_rom_arbiter_if
//   conflict_cnt  : saturating count of contended cycles in this frame
module sprite_rom_arbiter #(
  parameter int N_REQ     = 4,
  parameter int AW        = 12,
  parameter int DW        = 12,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  sprite_rom_arbiter_if.slave  bus,
  output logic [15:0]          conflict_cnt
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   count_q, count_d;

  logic [PW-1:0]   search;
  logic [PW-1:0]   gidx;
  logic            found;
  logic            do_rr;
  logic [N_REQ-1:0] grant_c;
  logic [AW-1:0]   sel_addr;
  logic            contended;
  int unsigned     sum;
  int unsigned     nreq;

  logic [N_REQ-1:0] tag_q [RD_LAT+1];

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(N_REQ - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      count_q <= count_d;
    end
  end

  // frame_start overrides the registered ptr/state for this cycle's
  // arbitration; a burst that ends falls straight through to the
  // round-robin search with the old owner placed last.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    count_d = count_q;
    grant_c = '0;
    gidx    = '0;
    found   = 1'b0;
    do_rr   = 1'b1;
    sum     = 0;
    search  = frame_start ? '0 : ptr_q;

    if (!frame_start && state_q == BURST) begin
      if (bus.req[owner_q] && bus.req_lock[owner_q] &&
          count_q < CW'(MAX_BURST)) begin
        found   = 1'b1;
        gidx    = owner_q;
        count_d = count_q + CW'(1);
        do_rr   = 1'b0;
      end else begin
        search = wrap_inc(owner_q);
      end
    end

    if (do_rr) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        sum = 32'(search) + k;
        if (!found && bus.req[PW'(sum % N_REQ)]) begin
          found = 1'b1;
          gidx  = PW'(sum % N_REQ);
        end
      end
      if (found && bus.req_lock[gidx]) begin
        state_d = BURST;
        owner_d = gidx;
        count_d = CW'(1);
        ptr_d   = search;
      end else begin
        state_d = IDLE;
        ptr_d   = found ? wrap_inc(gidx) : search;
      end
    end

    if (found) grant_c[gidx] = 1'b1;
    bus.grant = rst_n ? grant_c : '0;
    sel_addr  = bus.req_addr[int'(gidx)*AW +: AW];
  end

  always_comb begin
    nreq = 0;
    for (int unsigned k = 0; k < N_REQ; k++) nreq += 32'(bus.req[k]);
    contended = (nreq >= 2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (frame_start) begin
      conflict_cnt <= '0;
    end else if (contended && conflict_cnt != 16'hFFFF) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  // tag_q[0] travels with the issued read; tag_q[RD_LAT] lines up with rom_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rom_rden    <= 1'b0;
      bus.rom_addr    <= '0;
      bus.rdata       <= '0;
      bus.rdata_valid <= '0;
      for (int unsigned k = 0; k <= RD_LAT; k++) tag_q[k] <= '0;
    end else begin
      bus.rom_rden <= |bus.grant;
      if (|bus.grant) bus.rom_addr <= sel_addr;
      tag_q[0] <= bus.grant;
      for (int unsigned k = 1; k <= RD_LAT; k++) tag_q[k] <= tag_q[k-1];
      bus.rdata_valid <= tag_q[RD_LAT];
      if (|tag_q[RD_LAT]) bus.rdata <= bus.rom_q;
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
module tb_sprite_rom_arbiter;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic [15:0] conflict_cnt;
  logic [11:0] rom_p0, rom_p1;
  logic [11:0] addr_tab [4];
  int unsigned checks;
  int unsigned errors;

  sprite_rom_arbiter_if #(.N_REQ(4), .AW(12), .DW(12)) bus ();

  sprite_rom_arbiter #(
    .N_REQ(4), .AW(12), .DW(12), .RD_LAT(2), .MAX_BURST(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .bus          (bus.slave),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] rom_f(input logic [11:0] a);
    return a ^ 12'hA5A;
  endfunction

  // Two-cycle ROM model: address seen in cycle c -> data visible in c+2.
  always @(posedge clk) begin
    rom_p0 <= rom_f(bus.rom_addr);
    rom_p1 <= rom_p0;
  end
  assign bus.rom_q = rom_p1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [11:0] a);
    bus.req_addr[i*12 +: 12] = a;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    frame_start = 1'b0;
    bus.req = '0;
    bus.req_lock = '0;
    bus.req_addr = '0;
    addr_tab[0] = 12'h100;
    addr_tab[1] = 12'h211;
    addr_tab[2] = 12'h322;
    addr_tab[3] = 12'h433;

    // Reset state, grant suppressed even with requests present
    repeat (2) @(negedge clk);
    bus.req = 4'b1111;
    #1;
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_rden", 32'(bus.rom_rden), 0);
    check("rst_addr", 32'(bus.rom_addr), 0);
    check("rst_rdata", 32'(bus.rdata), 0);
    check("rst_rdv", 32'(bus.rdata_valid), 0);
    check("rst_cnt", 32'(conflict_cnt), 0);
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request latency
    bus.req = 4'b0001;
    set_addr(0, 12'h005);
    #1 check("single_grant", 32'(bus.grant), 32'h1);
    @(negedge clk);
    bus.req = '0;
    #1;
    check("single_grant_off", 32'(bus.grant), 0);
    check("single_rden", 32'(bus.rom_rden), 1);
    check("single_addr", 32'(bus.rom_addr), 32'h005);
    @(negedge clk);
    #1;
    check("single_rden_off", 32'(bus.rom_rden), 0);
    check("single_addr_hold", 32'(bus.rom_addr), 32'h005);
    check("single_rdv_t2", 32'(bus.rdata_valid), 0);
    @(negedge clk);
    #1 check("single_rdv_t3", 32'(bus.rdata_valid), 0);
    @(negedge clk);
    #1;
    check("single_rdv_t4", 32'(bus.rdata_valid), 32'h1);
    check("single_rdata", 32'(bus.rdata), 32'(rom_f(12'h005)));
    repeat (4) @(negedge clk);

    // All four requesting, frame_start resets ptr to 0
    for (int i = 0; i < 4; i++) set_addr(i, addr_tab[i]);
    bus.req = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      frame_start = (k == 0);
      #1;
      check("rr_grant", 32'(bus.grant), 32'(1 << (k % 4)));
      if (k >= 1) check("rr_cnt", 32'(conflict_cnt), 32'(k - 1));
      if (k >= 4) begin
        check("rr_rdv", 32'(bus.rdata_valid), 32'(1 << ((k - 4) % 4)));
        check("rr_rdata", 32'(bus.rdata), 32'(rom_f(addr_tab[(k - 4) % 4])));
      end else begin
        check("rr_rdv_idle", 32'(bus.rdata_valid), 0);
      end
      @(negedge clk);
    end
    frame_start = 1'b0;
    bus.req = '0;
    repeat (6) @(negedge clk);

    // Locked burst of requester 1 against requester 2
    bus.req = 4'b0110;
    bus.req_lock = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      #1 check("lock_grant", 32'(bus.grant), (k == 16) ? 32'h4 : 32'h2);
      @(negedge clk);
    end
    bus.req = '0;
    bus.req_lock = '0;
    #1 check("lock_exit_grant", 32'(bus.grant), 0);
    @(negedge clk);

    // frame_start with ptr=2 and conflict_cnt=37
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    bus.req = 4'b0011;
    for (int k = 0; k < 37; k++) begin
      #1 check("fs_pre_grant", 32'(bus.grant), (k % 2 == 0) ? 32'h1 : 32'h2);
      @(negedge clk);
    end
    bus.req = 4'b0010;
    #1;
    check("fs_set_ptr_grant", 32'(bus.grant), 32'h2);
    check("fs_cnt_37", 32'(conflict_cnt), 32'd37);
    @(negedge clk);
    bus.req = 4'b1111;
    frame_start = 1'b1;
    #1;
    check("fs_grant_from0", 32'(bus.grant), 32'h1);
    check("fs_cnt_before", 32'(conflict_cnt), 32'd37);
    @(negedge clk);
    bus.req = '0;
    frame_start = 1'b0;
    #1 check("fs_cnt_clear", 32'(conflict_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    #1 check("fs_rdv_pending", 32'(bus.rdata_valid), 32'h2);
    @(negedge clk);
    #1 check("fs_rdv_fsgrant", 32'(bus.rdata_valid), 32'h1);
    repeat (5) @(negedge clk);

    // Reset two cycles after a grant
    bus.req = 4'b0001;
    set_addr(0, 12'h0AB);
    #1 check("rst_mid_grant", 32'(bus.grant), 32'h1);
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = 4'b1111;
    #1;
    check("rst_mid_grant_off", 32'(bus.grant), 0);
    check("rst_mid_rden", 32'(bus.rom_rden), 0);
    check("rst_mid_addr", 32'(bus.rom_addr), 0);
    check("rst_mid_rdata", 32'(bus.rdata), 0);
    check("rst_mid_rdv", 32'(bus.rdata_valid), 0);
    check("rst_mid_cnt", 32'(conflict_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = '0;
    for (int k = 0; k < 4; k++) begin
      #1 check("rst_mid_no_rdv", 32'(bus.rdata_valid), 0);
      @(negedge clk);
    end

    // Saturation of conflict_cnt
    bus.req = 4'b0011;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (65534) @(negedge clk);
    #1 check("sat_fffe", 32'(conflict_cnt), 32'hFFFE);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 check("sat_ffff", 32'(conflict_cnt), 32'hFFFF);
    end
    bus.req = '0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
